// File: rtl/if_pc_gen_pkg.sv
// Shared memory-map constants for the fetch stage and the address checkers.
package if_pc_gen_pkg;

  localparam logic [31:0] TEXT_STARTADDR  = 32'h0000_3000;
  localparam logic [31:0] KTEXT_STARTADDR = 32'h0000_4180;
  localparam logic [31:0] IM_SIZE         = 32'h0000_4000;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

endpackage

// File: rtl/if_fetch_check.sv
// Combinational fetch address checker: flags misaligned or out-of-range PCs as AdEL.
module if_fetch_check
  import if_pc_gen_pkg::*;
#(
  parameter logic [31:0] IM_BASE  = TEXT_STARTADDR,
  parameter logic [31:0] IM_BYTES = IM_SIZE
) (
  input  logic [31:0] pc,
  output logic [4:0]  exc_code
);

  logic [31:0] offset;
  logic        above_base;
  logic        in_range;
  logic        misaligned;

  // Offset is only meaningful once pc >= IM_BASE, so the subtraction cannot underflow where it matters.
  assign offset     = pc - IM_BASE;
  assign above_base = (pc >= IM_BASE);
  assign in_range   = above_base && (offset < IM_BYTES);
  assign misaligned = |pc[1:0];

  assign exc_code = (misaligned || !in_range) ? EXC_ADEL : EXC_NONE;

endmodule

// File: rtl/if_pc_gen.sv
// IF-stage program counter: picks the next fetch address and tags each fetch with delay-slot and AdEL info.
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = TEXT_STARTADDR,
  parameter logic [31:0] HANDLER_PC = KTEXT_STARTADDR,
  parameter logic [31:0] IM_BASE    = TEXT_STARTADDR,
  parameter logic [31:0] IM_BYTES   = IM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_flush,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_is_jb,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic        is_bd,
  output logic [4:0]  exc_code
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        bd_q;
  logic        bd_d;

  // Exceptions and ERET override a stall; a stalled branch is re-presented by ID later.
  always_comb begin
    pc_d = pc_q + 32'd4;
    bd_d = id_is_jb;
    if (exc_flush) begin
      pc_d = HANDLER_PC;
      bd_d = 1'b0;
    end else if (eret) begin
      pc_d = epc;
      bd_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
      bd_d = bd_q;
    end else if (br_taken) begin
      pc_d = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      bd_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      bd_q <= bd_d;
    end
  end

  assign pc       = pc_q;
  assign is_bd    = bd_q;
  assign pc_plus8 = pc_q + 32'd8;

  if_fetch_check #(
    .IM_BASE  (IM_BASE),
    .IM_BYTES (IM_BYTES)
  ) u_fetch_check (
    .pc       (pc_q),
    .exc_code (exc_code)
  );

endmodule

// File: tb/tb_if_pc_gen.sv
// Scoreboard bench for if_pc_gen: directed test-plan sequences followed by randomized control traffic.
module tb_if_pc_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        exc_flush;
  logic        eret;
  logic [31:0] epc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_is_jb;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        is_bd;
  logic [4:0]  exc_code;

  typedef struct {
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] mpc;
  logic        mbd;

  if_pc_gen dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .exc_flush (exc_flush),
    .eret      (eret),
    .epc       (epc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .id_is_jb  (id_is_jb),
    .pc        (pc),
    .pc_plus8  (pc_plus8),
    .is_bd     (is_bd),
    .exc_code  (exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fetch legality from the memory map, using wide arithmetic so no wrap can hide an error.
  function automatic logic [4:0] model_exc(input logic [31:0] a);
    longint unsigned addr;
    addr = longint'(a);
    if ((addr % 4) != 0) return 5'd4;
    if (addr < 64'h3000) return 5'd4;
    if (addr >= 64'h3000 + 64'h4000) return 5'd4;
    return 5'd0;
  endfunction

  task automatic applyStimulus(input logic r, input logic st, input logic ef, input logic er,
                               input logic [31:0] ep, input logic bt, input logic [31:0] tg,
                               input logic jb);
    exp_t e;
    reset = r; stall = st; exc_flush = ef; eret = er;
    epc = ep; br_taken = bt; br_target = tg; id_is_jb = jb;
    @(posedge clk);
    if (r) begin
      mpc = 32'h3000; mbd = 1'b0;
    end else if (ef) begin
      mpc = 32'h4180; mbd = 1'b0;
    end else if (er) begin
      mpc = ep; mbd = 1'b0;
    end else if (st) begin
      mpc = mpc; mbd = mbd;
    end else begin
      mpc = bt ? tg : 32'((64'(mpc) + 64'd4) % 64'h1_0000_0000);
      mbd = jb;
    end
    e.pc = mpc; e.bd = mbd; e.exc = model_exc(mpc);
    sb.push_back(e);
    #1;
  endtask

  task automatic freeCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic redirect(input logic [31:0] tg, input logic jb);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, tg, jb);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] p8;
    p8 = 32'((64'(e.pc) + 64'd8) % 64'h1_0000_0000);
    checks++;
    if (pc !== e.pc) begin
      errors++;
      $display("[TB] FAIL pc: got %h expected %h at %0t", pc, e.pc, $time);
    end
    checks++;
    if (is_bd !== e.bd) begin
      errors++;
      $display("[TB] FAIL is_bd: got %b expected %b (pc %h) at %0t", is_bd, e.bd, e.pc, $time);
    end
    checks++;
    if (exc_code !== e.exc) begin
      errors++;
      $display("[TB] FAIL exc_code: got %0d expected %0d (pc %h) at %0t", exc_code, e.exc, e.pc, $time);
    end
    checks++;
    if (pc_plus8 !== p8) begin
      errors++;
      $display("[TB] FAIL pc_plus8: got %h expected %h at %0t", pc_plus8, p8, $time);
    end
  endtask

  // Monitor: the DUT presents a fetch every cycle, so one expectation is retired per falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) checkOutput(sb.pop_front());
  end

  initial begin
    logic [31:0] tgt;
    logic [31:0] ep;
    mpc = 32'h0; mbd = 1'b0;
    reset = 1'b1; stall = 1'b0; exc_flush = 1'b0; eret = 1'b0;
    epc = 32'h0; br_taken = 1'b0; br_target = 32'h0; id_is_jb = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5000, 1'b1);

    repeat (4) freeCycle();
    redirect(32'h3100, 1'b1);
    freeCycle();

    redirect(32'h3010, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3100, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3100, 1'b0);
    redirect(32'h3100, 1'b1);

    redirect(32'h3020, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h3024, 1'b1, 32'h3300, 1'b1);
    freeCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h3024, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h3026, 1'b1, 32'h3300, 1'b0);
    freeCycle();

    redirect(32'h6FF8, 1'b0);
    freeCycle();
    freeCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3400, 1'b1);

    redirect(32'h2FFC, 1'b0);
    redirect(32'hFFFF_FFFC, 1'b1);
    freeCycle();

    for (int i = 0; i < 400; i++) begin
      tgt = (($urandom_range(0, 7) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 32'hFFF) << 2)));
      ep  = (($urandom_range(0, 5) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 32'hFFF) << 2)));
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 14) == 0,
                    ep,
                    $urandom_range(0, 4) == 0,
                    tgt,
                    $urandom_range(0, 3) == 0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
